// File: rtl/signed_fixed_point_long_divider_pkg.sv
// Shared types and sizing helpers for the signed fixed-point long divider.
package signed_fixed_div_pkg;

   // Handshake / sequencing states of the divider.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Number of restoring iterations: one quotient bit per numerator bit.
   function automatic int calc_iters(input int data_w, input int frac_w);
      return data_w + frac_w;
   endfunction

   // Accept-to-valid latency: K iterations plus the FIX cycle.
   function automatic int calc_latency(input int data_w, input int frac_w);
      return calc_iters(data_w, frac_w) + 1;
   endfunction

endpackage

// File: rtl/signed_fixed_point_long_divider_core.sv
// Unsigned restoring long-division core: divides (dividend << FRAC_W) by the
// divisor magnitude, producing one quotient bit per clock for K clocks.
module unsigned_long_div_core
   import signed_fixed_div_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic                                       i_clk,
   input  logic                                       i_reset,
   input  logic                                       i_start,
   input  logic [DATA_W-1:0]                          i_dividend_mag,
   input  logic [DATA_W-1:0]                          i_divisor_mag,
   output logic                                       o_last,
   output logic [calc_iters(DATA_W, FRAC_W)-1:0]      o_quot_mag
);

   localparam int K     = calc_iters(DATA_W, FRAC_W);
   localparam int CNT_W = $clog2(K + 1);

   logic [CNT_W-1:0]  count_q, count_d;
   logic [K-1:0]      num_q, num_d;
   logic [DATA_W:0]   rem_q, rem_d;
   logic [K-1:0]      quot_q, quot_d;
   logic [DATA_W-1:0] div_q, div_d;

   logic [DATA_W:0]   rem_shift;
   logic [DATA_W+1:0] trial;

   // One restoring step per cycle while iterations remain; load on start.
   always_comb begin
      count_d   = count_q;
      num_d     = num_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      div_d     = div_q;
      rem_shift = {rem_q[DATA_W-1:0], num_q[K-1]};
      trial     = {1'b0, rem_shift} - {2'b00, div_q};
      if (i_start) begin
         count_d = CNT_W'(K);
         num_d   = K'(i_dividend_mag) << FRAC_W;
         rem_d   = '0;
         quot_d  = '0;
         div_d   = i_divisor_mag;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
         num_d   = num_q << 1;
         quot_d  = {quot_q[K-2:0], ~trial[DATA_W+1]};
         // A negative trial restores the shifted remainder.
         rem_d   = trial[DATA_W+1] ? rem_shift : trial[DATA_W:0];
      end
   end

   // Iteration counter is the only control state; reset abandons the loop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Datapath registers carry no reset; they are reloaded on every start.
   always_ff @(posedge i_clk) begin
      num_q  <= num_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      div_q  <= div_d;
   end

   assign o_last     = (count_q == CNT_W'(1));
   assign o_quot_mag = quot_q;

endmodule

// File: rtl/signed_fixed_point_long_divider.sv
// Signed Q(DATA_W-FRAC_W).FRAC_W divider with valid/ready handshake,
// divide-by-zero and overflow flags, and saturating, truncating output.
module signed_fixed_point_long_divider
   import signed_fixed_div_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic signed [DATA_W-1:0] i_dividend,
   input  logic signed [DATA_W-1:0] i_divisor,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic signed [DATA_W-1:0] o_quotient,
   output logic                     o_div_by_zero,
   output logic                     o_overflow
);

   localparam int K = calc_iters(DATA_W, FRAC_W);

   // Magnitude of a two's complement value; the most negative value maps to
   // 2^(DATA_W-1), which still fits as unsigned.
   function automatic logic [DATA_W-1:0] mag_of(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
   endfunction

   // Applies sign, saturation and divide-by-zero forcing; returns {ovf, quotient}.
   function automatic logic [DATA_W:0] saturate_result(
      input logic [K-1:0] mag,
      input logic         neg,
      input logic         zero_div,
      input logic         dvd_neg
   );
      logic [K-1:0]      neg_lim;
      logic [K-1:0]      pos_lim;
      logic [DATA_W-1:0] max_val;
      logic [DATA_W-1:0] min_val;
      logic [DATA_W-1:0] low;
      logic [DATA_W-1:0] res;
      neg_lim              = '0;
      neg_lim[DATA_W-1]    = 1'b1;
      pos_lim              = neg_lim - K'(1);
      max_val              = '1;
      max_val[DATA_W-1]    = 1'b0;
      min_val              = '0;
      min_val[DATA_W-1]    = 1'b1;
      low                  = mag[DATA_W-1:0];
      res                  = -low;
      if (zero_div) begin
         return {1'b0, dvd_neg ? min_val : max_val};
      end else if (neg) begin
         // Exactly -2^(DATA_W-1) is representable; zero magnitude negates to 0.
         if (mag > neg_lim) return {1'b1, min_val};
         else               return {1'b0, res};
      end else begin
         if (mag > pos_lim) return {1'b1, max_val};
         else               return {1'b0, low};
      end
   endfunction

   div_state_e        state_q, state_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic              div_by_zero_q, div_by_zero_d;
   logic              overflow_q, overflow_d;

   logic              res_neg_q, res_neg_d;
   logic              zero_div_q, zero_div_d;
   logic              dvd_neg_q, dvd_neg_d;

   logic              accept;
   logic              core_last;
   logic [K-1:0]      core_quot;

   assign accept = i_valid && ready_q;

   unsigned_long_div_core #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_core (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_start        (accept),
      .i_dividend_mag (mag_of(i_dividend)),
      .i_divisor_mag  (mag_of(i_divisor)),
      .o_last         (core_last),
      .o_quot_mag     (core_quot)
   );

   // Handshake FSM next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      ready_d       = ready_q;
      valid_d       = valid_q;
      quot_d        = quot_q;
      div_by_zero_d = div_by_zero_q;
      overflow_d    = overflow_q;
      res_neg_d     = res_neg_q;
      zero_div_d    = zero_div_q;
      dvd_neg_d     = dvd_neg_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               res_neg_d  = i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1];
               zero_div_d = (i_divisor == '0);
               dvd_neg_d  = i_dividend[DATA_W-1];
               ready_d    = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            if (core_last) state_d = FIX;
         end
         FIX: begin
            {overflow_d, quot_d} = saturate_result(core_quot, res_neg_q, zero_div_q, dvd_neg_q);
            div_by_zero_d        = zero_div_q;
            valid_d              = 1'b1;
            state_d              = DONE;
         end
         DONE: begin
            if (i_ready) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   // FSM state and visible outputs; reset wins over any handshake.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= IDLE;
         ready_q       <= 1'b1;
         valid_q       <= 1'b0;
         quot_q        <= '0;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         valid_q       <= valid_d;
         quot_q        <= quot_d;
         div_by_zero_q <= div_by_zero_d;
         overflow_q    <= overflow_d;
      end
   end

   // Operand attributes captured at accept; only meaningful during CALC/FIX.
   always_ff @(posedge i_clk) begin
      res_neg_q  <= res_neg_d;
      zero_div_q <= zero_div_d;
      dvd_neg_q  <= dvd_neg_d;
   end

   assign o_ready       = ready_q;
   assign o_valid       = valid_q;
   assign o_quotient    = quot_q;
   assign o_div_by_zero = div_by_zero_q;
   assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_signed_fixed_point_long_divider.sv
// Directed self-checking bench for signed_fixed_point_long_divider (Q8.8).
module tb_signed_fixed_point_long_divider;
   import signed_fixed_div_pkg::*;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int LAT    = calc_latency(DATA_W, FRAC_W);

   logic               clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_valid = 1'b0;
   logic               o_ready;
   logic signed [15:0] i_dividend = '0;
   logic signed [15:0] i_divisor = '0;
   logic               o_valid;
   logic               i_ready = 1'b0;
   logic signed [15:0] o_quotient;
   logic               o_div_by_zero;
   logic               o_overflow;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   signed_fixed_point_long_divider #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_dividend    (i_dividend),
      .i_divisor     (i_divisor),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_quotient    (o_quotient),
      .o_div_by_zero (o_div_by_zero),
      .o_overflow    (o_overflow)
   );

   // Stimulus only: issue one division, wait (bounded) for o_valid, capture,
   // then complete the handshake and capture the post-handshake status.
   task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic dz, output logic ovf,
                          output int lat, output logic rdy_calc,
                          output logic rdy_after, output logic vld_after);
      bit seen;
      @(negedge clk);
      i_dividend = a;
      i_divisor  = b;
      i_valid    = 1'b1;
      i_ready    = 1'b0;
      @(posedge clk);
      #1;
      i_valid    = 1'b0;
      i_dividend = 16'sh5A5A;
      i_divisor  = 16'sh0003;
      rdy_calc   = o_ready;
      lat  = -1;
      seen = 1'b0;
      q    = 'x;
      dz   = 1'bx;
      ovf  = 1'bx;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (o_valid === 1'b1) begin
            seen = 1'b1;
            lat  = c;
            q    = o_quotient;
            dz   = o_div_by_zero;
            ovf  = o_overflow;
         end
      end
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready   = 1'b0;
      rdy_after = o_ready;
      vld_after = o_valid;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      i_reset = 1'b0;
      tests_run++;
      if ({o_ready, o_valid, o_quotient, o_div_by_zero, o_overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy=%b vld=%b q=%h dz=%b ovf=%b, want rdy=1 vld=0 q=0000 dz=0 ovf=0",
                  o_ready, o_valid, o_quotient, o_div_by_zero, o_overflow);
      end
   endtask

   task automatic test_basic();
      logic [15:0] a_t [2] = '{16'h0300, 16'hFD00};
      logic [15:0] e_t [2] = '{16'h0180, 16'hFE80};
      logic [15:0] q;
      logic dz, ovf, rc, ra, va;
      int lat;
      for (int i = 0; i < 2; i++) begin
         run_div(a_t[i], 16'h0200, q, dz, ovf, lat, rc, ra, va);
         tests_run++;
         if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL basic_latency[%0d]: got %0d cycles, want %0d", i, lat, LAT);
         end
         tests_run++;
         if ({q, dz, ovf} !== {e_t[i], 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_result[%0d]: got q=%h dz=%b ovf=%b, want q=%h dz=0 ovf=0", i, q, dz, ovf, e_t[i]);
         end
         tests_run++;
         if (rc !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ready_busy[%0d]: got o_ready=%b during calc, want 0", i, rc);
         end
         tests_run++;
         if ({ra, va} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_handshake[%0d]: got rdy=%b vld=%b, want rdy=1 vld=0", i, ra, va);
         end
      end
   endtask

   task automatic test_truncation();
      logic [15:0] a_t [3] = '{16'h0100, 16'hFF00, 16'h0000};
      logic [15:0] b_t [3] = '{16'h0300, 16'h0300, 16'hFF00};
      logic [15:0] e_t [3] = '{16'h0055, 16'hFFAB, 16'h0000};
      logic [15:0] q;
      logic dz, ovf, rc, ra, va;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_div(a_t[i], b_t[i], q, dz, ovf, lat, rc, ra, va);
         tests_run++;
         if ({q, dz, ovf} !== {e_t[i], 1'b0, 1'b0} || lat !== LAT) begin
            tests_failed++;
            $display("FAIL trunc[%0d]: got q=%h dz=%b ovf=%b lat=%0d, want q=%h dz=0 ovf=0 lat=%0d",
                     i, q, dz, ovf, lat, e_t[i], LAT);
         end
      end
   endtask

   task automatic test_overflow();
      logic [15:0] a_t [3] = '{16'h7F00, 16'h8000, 16'h8000};
      logic [15:0] b_t [3] = '{16'h0080, 16'hFF00, 16'h0100};
      logic [15:0] e_t [3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
      logic        o_t [3] = '{1'b1, 1'b1, 1'b0};
      logic [15:0] q;
      logic dz, ovf, rc, ra, va;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_div(a_t[i], b_t[i], q, dz, ovf, lat, rc, ra, va);
         tests_run++;
         if ({q, dz, ovf} !== {e_t[i], 1'b0, o_t[i]} || lat !== LAT) begin
            tests_failed++;
            $display("FAIL ovf[%0d]: got q=%h dz=%b ovf=%b lat=%0d, want q=%h dz=0 ovf=%b lat=%0d",
                     i, q, dz, ovf, lat, e_t[i], o_t[i], LAT);
         end
      end
   endtask

   task automatic test_div_by_zero();
      logic [15:0] a_t [3] = '{16'h0100, 16'hFF00, 16'h0000};
      logic [15:0] e_t [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
      logic [15:0] q;
      logic dz, ovf, rc, ra, va;
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_div(a_t[i], 16'h0000, q, dz, ovf, lat, rc, ra, va);
         tests_run++;
         if ({q, dz, ovf} !== {e_t[i], 1'b1, 1'b0} || lat !== LAT) begin
            tests_failed++;
            $display("FAIL dbz[%0d]: got q=%h dz=%b ovf=%b lat=%0d, want q=%h dz=1 ovf=0 lat=%0d",
                     i, q, dz, ovf, lat, e_t[i], LAT);
         end
      end
   endtask

   task automatic test_backpressure();
      bit seen;
      int lat;
      @(negedge clk);
      i_dividend = 16'sh0300;
      i_divisor  = 16'sh0200;
      i_valid    = 1'b1;
      i_ready    = 1'b0;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      seen = 1'b0;
      lat  = -1;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (o_valid === 1'b1) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      tests_run++;
      if (lat !== LAT) begin
         tests_failed++;
         $display("FAIL bp_latency: got %0d cycles, want %0d", lat, LAT);
      end
      for (int i = 0; i < 10; i++) begin
         i_valid    = i[0];
         i_dividend = 16'sh0100;
         i_divisor  = 16'sh0100;
         @(posedge clk);
         #1;
         tests_run++;
         if ({o_valid, o_ready, o_quotient, o_div_by_zero, o_overflow} !== {1'b1, 1'b0, 16'h0180, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%h dz=%b ovf=%b, want vld=1 rdy=0 q=0180 dz=0 ovf=0",
                     i, o_valid, o_ready, o_quotient, o_div_by_zero, o_overflow);
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
      tests_run++;
      if ({o_ready, o_valid, o_quotient} !== {1'b1, 1'b0, 16'h0180}) begin
         tests_failed++;
         $display("FAIL bp_release: got rdy=%b vld=%b q=%h, want rdy=1 vld=0 q=0180", o_ready, o_valid, o_quotient);
      end
   endtask

   task automatic test_reset_mid_op();
      bit stray;
      logic [15:0] q;
      logic dz, ovf, rc, ra, va;
      int lat;
      // Leave a nonzero, flagged result on the outputs first.
      run_div(16'h7F00, 16'h0080, q, dz, ovf, lat, rc, ra, va);
      @(negedge clk);
      i_dividend = 16'sh0300;
      i_divisor  = 16'sh0200;
      i_valid    = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      i_reset = 1'b1;
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      tests_run++;
      if ({o_ready, o_valid, o_quotient, o_div_by_zero, o_overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_mid_state: got rdy=%b vld=%b q=%h dz=%b ovf=%b, want rdy=1 vld=0 q=0000 dz=0 ovf=0",
                  o_ready, o_valid, o_quotient, o_div_by_zero, o_overflow);
      end
      stray = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (o_valid !== 1'b0) stray = 1'b1;
      end
      tests_run++;
      if (stray !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_no_valid: got o_valid=1 after reset, want none");
      end
      run_div(16'h0300, 16'h0200, q, dz, ovf, lat, rc, ra, va);
      tests_run++;
      if ({q, dz, ovf} !== {16'h0180, 1'b0, 1'b0} || lat !== LAT) begin
         tests_failed++;
         $display("FAIL rst_mid_recover: got q=%h dz=%b ovf=%b lat=%0d, want q=0180 dz=0 ovf=0 lat=%0d",
                  q, dz, ovf, lat, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncation();
      test_overflow();
      test_div_by_zero();
      test_backpressure();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
